// File: rtl/cmul_pkg.sv
// cmul_pkg
//   Shared types and default constants for the complex-multiplier arbiter slice.
//   cplx_t       : packed complex value, re/im each CMUL_SIZE bits (signed fixed point)
//   CMUL_SIZE    : default operand/result width
//   CMUL_FRAC    : default number of fractional bits
//   CMUL_NUM_REQ : default number of requesters
package cmul_pkg;

  localparam int CMUL_SIZE    = 16;
  localparam int CMUL_FRAC    = 8;
  localparam int CMUL_NUM_REQ = 4;

  typedef struct packed {
    logic [CMUL_SIZE-1:0] re;
    logic [CMUL_SIZE-1:0] im;
  } cplx_t;

endpackage

// File: rtl/cmul_arbiter_mult.sv
// ComplexMultipler
//   Combinational signed fixed-point complex multiply p = a * b.
//   Full-precision products are rounded half-up at FRAC_BITS and saturated to SIZE bits.
//   Ports:
//     a_real, a_cplx, b_real, b_cplx : in  SIZE, operands
//     p_real, p_cplx                 : out SIZE, product
module ComplexMultipler
  import cmul_pkg::*;
#(
  parameter int SIZE      = CMUL_SIZE,
  parameter int FRAC_BITS = CMUL_FRAC
) (
  input  logic [SIZE-1:0] a_real,
  input  logic [SIZE-1:0] a_cplx,
  input  logic [SIZE-1:0] b_real,
  input  logic [SIZE-1:0] b_cplx,
  output logic [SIZE-1:0] p_real,
  output logic [SIZE-1:0] p_cplx
);

  localparam int PW = 2 * SIZE;
  // Two extra bits: one for the sum of two products, one of headroom for rounding.
  localparam int W  = 2 * SIZE + 2;

  localparam logic signed [W-1:0] MAXV = W'((2 ** (SIZE - 1)) - 1);
  localparam logic signed [W-1:0] MINV = ~MAXV;
  localparam logic signed [W-1:0] RND  = (FRAC_BITS > 0) ? (W'(1) << (FRAC_BITS - 1)) : '0;

  logic signed [PW-1:0] ar_x, ai_x, br_x, bi_x;
  logic signed [PW-1:0] m_rr, m_ii, m_ri, m_ir;
  logic signed [W-1:0]  sum_re, sum_im;

  function automatic logic [SIZE-1:0] round_sat(input logic signed [W-1:0] v);
    logic signed [W-1:0] r;
    r = (v + RND) >>> FRAC_BITS;
    if (r > MAXV) begin
      r = MAXV;
    end else if (r < MINV) begin
      r = MINV;
    end
    return r[SIZE-1:0];
  endfunction

  assign ar_x = PW'($signed(a_real));
  assign ai_x = PW'($signed(a_cplx));
  assign br_x = PW'($signed(b_real));
  assign bi_x = PW'($signed(b_cplx));

  assign m_rr = ar_x * br_x;
  assign m_ii = ai_x * bi_x;
  assign m_ri = ar_x * bi_x;
  assign m_ir = ai_x * br_x;

  assign sum_re = W'(m_rr) - W'(m_ii);
  assign sum_im = W'(m_ri) + W'(m_ir);

  assign p_real = round_sat(sum_re);
  assign p_cplx = round_sat(sum_im);

endmodule

// File: rtl/cmul_arbiter_rr.sv
// rr_arbiter
//   Round-robin grant over N requesters. The search starts one past the last
//   accepted requester and wraps; the pointer only moves on an accepted transfer.
//   Ports:
//     clk, rst_n : clock, async active-low reset
//     req        : in  N, request vector
//     adv        : in  1, pipeline advance (a grant is accepted when high)
//     grant      : out N, one-hot or zero
//     grant_id   : out ID_W, encoded grant
module rr_arbiter
  import cmul_pkg::*;
#(
  parameter int N    = CMUL_NUM_REQ,
  parameter int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            adv,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);

  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W:0]   cand;
  logic            grant_any;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N)) begin
        cand = cand - (ID_W+1)'(N);
      end
      if (!grant_any && req[cand[ID_W-1:0]]) begin
        grant_any                = 1'b1;
        grant[cand[ID_W-1:0]]    = 1'b1;
        grant_id                 = cand[ID_W-1:0];
      end
    end
  end

  assign last_d = (adv && grant_any) ? grant_id : last_q;

  // Reset to N-1 so requester 0 is first in the search order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= ID_W'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/cmul_arbiter.sv
// cmul_arbiter
//   Shares one ComplexMultipler between NUM_REQ requesters. One requester is
//   granted per cycle (round-robin); its operands drive the multiplier and the
//   product is registered together with the requester index.
//   Optional feature macro: CMUL_IN_REG_EN -- adds a stage-1 register for the
//   muxed operands/id/valid in front of the multiplier (2-cycle latency).
//   Ports:
//     clk, rst_n                  : clock, async active-low reset
//     req_valid / req_ready       : per-requester handshake (ready one-hot or zero)
//     req_a_real .. req_b_cplx    : packed operands, slice i = requester i
//     out_valid / out_ready       : result handshake
//     out_real, out_cplx, out_id  : registered product and issuing requester
//     busy                        : any pipeline stage holds a valid entry
module cmul_arbiter
  import cmul_pkg::*;
#(
  parameter int SIZE      = CMUL_SIZE,
  parameter int FRAC_BITS = CMUL_FRAC,
  parameter int NUM_REQ   = CMUL_NUM_REQ,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*SIZE-1:0] req_a_real,
  input  logic [NUM_REQ*SIZE-1:0] req_a_cplx,
  input  logic [NUM_REQ*SIZE-1:0] req_b_real,
  input  logic [NUM_REQ*SIZE-1:0] req_b_cplx,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SIZE-1:0]         out_real,
  output logic [SIZE-1:0]         out_cplx,
  output logic [ID_W-1:0]         out_id,
  output logic                    busy
);

  logic               adv;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               grant_any;
  logic [SIZE-1:0]    mux_ar, mux_ai, mux_br, mux_bi;
  logic [SIZE-1:0]    m_ar, m_ai, m_br, m_bi;
  logic [SIZE-1:0]    p_re, p_im;
  logic               cap_valid;
  logic [ID_W-1:0]    cap_id;

  logic               out_valid_q;
  logic [SIZE-1:0]    out_real_q, out_cplx_q;
  logic [ID_W-1:0]    out_id_q;

  assign adv = !out_valid_q || out_ready;

  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid),
    .adv      (adv),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign grant_any = |grant;
  // Gated by rst_n so nothing is accepted while the pipeline is held in reset.
  assign req_ready = (adv && rst_n) ? grant : '0;

  always_comb begin
    mux_ar = '0;
    mux_ai = '0;
    mux_br = '0;
    mux_bi = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        mux_ar = req_a_real[i*SIZE +: SIZE];
        mux_ai = req_a_cplx[i*SIZE +: SIZE];
        mux_br = req_b_real[i*SIZE +: SIZE];
        mux_bi = req_b_cplx[i*SIZE +: SIZE];
      end
    end
  end

`ifdef CMUL_IN_REG_EN
  logic            s1_valid_q;
  logic [SIZE-1:0] s1_ar_q, s1_ai_q, s1_br_q, s1_bi_q;
  logic [ID_W-1:0] s1_id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_ar_q    <= '0;
      s1_ai_q    <= '0;
      s1_br_q    <= '0;
      s1_bi_q    <= '0;
      s1_id_q    <= '0;
    end else if (adv) begin
      s1_valid_q <= grant_any;
      if (grant_any) begin
        s1_ar_q <= mux_ar;
        s1_ai_q <= mux_ai;
        s1_br_q <= mux_br;
        s1_bi_q <= mux_bi;
        s1_id_q <= grant_id;
      end
    end
  end

  assign m_ar      = s1_ar_q;
  assign m_ai      = s1_ai_q;
  assign m_br      = s1_br_q;
  assign m_bi      = s1_bi_q;
  assign cap_valid = s1_valid_q;
  assign cap_id    = s1_id_q;
  assign busy      = out_valid_q | s1_valid_q;
`else
  assign m_ar      = mux_ar;
  assign m_ai      = mux_ai;
  assign m_br      = mux_br;
  assign m_bi      = mux_bi;
  assign cap_valid = grant_any;
  assign cap_id    = grant_id;
  assign busy      = out_valid_q;
`endif

  ComplexMultipler #(.SIZE(SIZE), .FRAC_BITS(FRAC_BITS)) u_mul (
    .a_real (m_ar),
    .a_cplx (m_ai),
    .b_real (m_br),
    .b_cplx (m_bi),
    .p_real (p_re),
    .p_cplx (p_im)
  );

  // Data is only loaded with a valid entry, so it stays put across bubbles and stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_real_q  <= '0;
      out_cplx_q  <= '0;
      out_id_q    <= '0;
    end else if (adv) begin
      out_valid_q <= cap_valid;
      if (cap_valid) begin
        out_real_q <= p_re;
        out_cplx_q <= p_im;
        out_id_q   <= cap_id;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_real  = out_real_q;
  assign out_cplx  = out_cplx_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_cmul_arbiter.sv
module tb_cmul_arbiter;
  import cmul_pkg::*;

  localparam int SIZE = CMUL_SIZE;
  localparam int FRAC = CMUL_FRAC;
  localparam int N    = CMUL_NUM_REQ;
  localparam int IDW  = $clog2(N);
`ifdef CMUL_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N*SIZE-1:0]    req_a_real, req_a_cplx, req_b_real, req_b_cplx;
  logic                 out_valid;
  logic                 out_ready;
  logic [SIZE-1:0]      out_real, out_cplx;
  logic [IDW-1:0]       out_id;
  logic                 busy;

  cmul_arbiter #(.SIZE(SIZE), .FRAC_BITS(FRAC), .NUM_REQ(N), .ID_W(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a_real (req_a_real),
    .req_a_cplx (req_a_cplx),
    .req_b_real (req_b_real),
    .req_b_cplx (req_b_cplx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_real   (out_real),
    .out_cplx   (out_cplx),
    .out_id     (out_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    cplx_t          v;
    logic [IDW-1:0] id;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   res_cnt[N];
  int   m_last;
  logic m_ov, m_s1v;
  logic mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [SIZE-1:0] m_rs(input longint v);
    longint r;
    longint maxv;
    maxv = (longint'(1) <<< (SIZE - 1)) - 1;
    r = (v + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
    if (r > maxv) r = maxv;
    if (r < -maxv - 1) r = -maxv - 1;
    return SIZE'(r);
  endfunction

  function automatic cplx_t m_mul(input logic [SIZE-1:0] ar, ai, br, bi);
    longint sar, sai, sbr, sbi;
    cplx_t  res;
    sar = longint'($signed(ar));
    sai = longint'($signed(ai));
    sbr = longint'($signed(br));
    sbi = longint'($signed(bi));
    res.re = m_rs(sar * sbr - sai * sbi);
    res.im = m_rs(sar * sbi + sai * sbr);
    return res;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last = N - 1;
    m_ov   = 1'b0;
    m_s1v  = 1'b0;
    sbq.delete();
  endtask

  task automatic set_ops(input int i, input logic [SIZE-1:0] ar, ai, br, bi);
    req_a_real[i*SIZE +: SIZE] = ar;
    req_a_cplx[i*SIZE +: SIZE] = ai;
    req_b_real[i*SIZE +: SIZE] = br;
    req_b_cplx[i*SIZE +: SIZE] = bi;
  endtask

  // Cycle model + scoreboard: outputs checked against the model before each edge,
  // then the model is advanced to the state after that edge.
  always @(negedge clk) begin : mon
    logic adv_m;
    int   g;
    exp_t e;
    if (rst_n && mon_en) begin
      chk("out_valid", out_valid, m_ov);
      chk("busy", busy, m_ov | m_s1v);
      if (out_valid) begin
        chk("sb_pending", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          chk("out_real", out_real, sbq[0].v.re);
          chk("out_cplx", out_cplx, sbq[0].v.im);
          chk("out_id", out_id, sbq[0].id);
          if (out_ready) begin
            res_cnt[out_id]++;
            void'(sbq.pop_front());
          end
        end
      end
      adv_m = !m_ov || out_ready;
      g = rr_pick(req_valid, m_last);
      chk("req_ready", req_ready, (adv_m && g >= 0) ? (32'd1 << g) : 32'd0);
      chk("last_grant", dut.u_arb.last_q, m_last);
      if (adv_m) begin
        if (g >= 0) begin
          e.v  = m_mul(req_a_real[g*SIZE +: SIZE], req_a_cplx[g*SIZE +: SIZE],
                       req_b_real[g*SIZE +: SIZE], req_b_cplx[g*SIZE +: SIZE]);
          e.id = IDW'(g);
          sbq.push_back(e);
          m_last = g;
        end
`ifdef CMUL_IN_REG_EN
        m_ov  = m_s1v;
        m_s1v = (g >= 0);
`else
        m_ov  = (g >= 0);
`endif
      end
    end
  end

  // Called #2 after a rising edge; releases on the following falling edge with no requests.
  task automatic pulse_reset();
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_real", out_real, 0);
    chk("rst_out_cplx", out_cplx, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_busy", busy, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [SIZE-1:0] h_re, h_im;
    logic [IDW-1:0]  h_id;
    int              h_last, g, first, other;

    rst_n = 1'b0;
    out_ready = 1'b1;
    req_a_real = '0; req_a_cplx = '0; req_b_real = '0; req_b_cplx = '0;
    model_reset();
    for (int i = 0; i < N; i++) res_cnt[i] = 0;
    req_valid = '1;
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_real", out_real, 0);
    chk("reset_out_cplx", out_cplx, 0);
    chk("reset_out_id", out_id, 0);
    chk("reset_busy", busy, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_last_grant", dut.u_arb.last_q, N - 1);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Single product: (1+2i)*(3+4i) = -5+10i on requester 2
    @(posedge clk); #1;
    set_ops(2, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("single_ready", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    chk("single_valid", out_valid, 1);
    chk("single_real", out_real, 16'hFB00);
    chk("single_cplx", out_cplx, 16'h0A00);
    chk("single_id", out_id, 2);
    repeat (3) @(posedge clk);

    // Fairness from a fresh reset
    #2;
    pulse_reset();
    for (int i = 0; i < N; i++) begin
      res_cnt[i] = 0;
      set_ops(i, SIZE'($urandom), SIZE'($urandom), SIZE'($urandom), SIZE'($urandom));
    end
    @(posedge clk); #1;
    req_valid = '1;
    @(negedge clk);
    chk("fair_first_grant", req_ready, 4'b0001);
    repeat (8) @(posedge clk);
    #1 req_valid = '0;
    repeat (LAT + 2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) chk("fair_count", res_cnt[i], 2);

    // Back-pressure: 5 stalled cycles, granted requester drops valid mid-stall
    @(posedge clk); #1;
    req_valid = '1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_out_valid", out_valid, 1);
    h_re = out_real;
    h_im = out_cplx;
    h_id = out_id;
    h_last = m_last;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin
        g = rr_pick(req_valid, m_last);
        if (g >= 0) req_valid[g] = 1'b0;
      end
      @(negedge clk);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_hold_real", out_real, h_re);
      chk("bp_hold_cplx", out_cplx, h_im);
      chk("bp_hold_id", out_id, h_id);
      chk("bp_last_frozen", dut.u_arb.last_q, h_last);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    req_valid = '1;
    repeat (4) @(posedge clk);
    #1 req_valid = '0;
    repeat (LAT + 3) @(posedge clk);
    #1;
    chk("bp_drained", sbq.size(), 0);

    // Sparse: only requesters 1 and 3
    @(posedge clk); #1;
    req_valid = 4'b1010;
    first = rr_pick(4'b1010, m_last);
    other = (first == 1) ? 3 : 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("sparse_grant", req_ready, (c % 2 == 0) ? (32'd1 << first) : (32'd1 << other));
      @(posedge clk);
    end
    #1 req_valid = '0;
    repeat (LAT + 3) @(posedge clk);

    // Mid-flight reset with a valid result held
    @(posedge clk); #1;
    req_valid = '1;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_valid", out_valid, 1);
    pulse_reset();
    @(posedge clk); #1;
    req_valid = '1;
    @(negedge clk);
    chk("post_reset_grant", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (LAT + 3) @(posedge clk);
    #1;
    chk("final_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmul_arbiter.md
# cmul_arbiter

Round-robin arbiter and pipeline controller that shares one `ComplexMultipler` instance between `NUM_REQ` requesters, such as FFT butterflies, the filter tap engine and twiddle-correction logic. Each requester presents one complex operand pair under a valid/ready handshake. The block grants one requester per cycle, drives the shared multiplier, and returns the registered product tagged with the requester index. The block sits between the requester front-ends and the single multiplier datapath, so no requester needs its own four-multiplier instance.

## Interface
- `SIZE`, default 16: operand and result width; signed fixed point.
- `FRAC_BITS`, default 8: fractional bits; passed unchanged to the multiplier.
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester tag.

Ports:
- `clk`  in  1: single clock; all state is on the rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `req_valid`  in  NUM_REQ: per-requester operand valid.
- `req_ready`  out  NUM_REQ: per-requester accept; one-hot or zero.
- `req_a_real`, `req_a_cplx`, `req_b_real`, `req_b_cplx`  in  NUM_REQ×SIZE: packed operands; slice i belongs to requester i.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: downstream accept.
- `out_real`, `out_cplx`  out  SIZE each: product (a·b), real and imaginary parts.
- `out_id`  out  ID_W: index of the requester that issued the operation.
- `busy`  out  1: any pipeline stage holds a valid entry.

## Operation
- Transfers:
  - A transfer on requester i occurs when `req_valid[i] && req_ready[i]`.
  - A transfer on the output occurs when `out_valid && out_ready`.
- Back-pressure: `adv = !out_valid || out_ready`. `adv` is the single advance signal for the whole pipeline, and every stage stalls together when it is low.
- Grant:
  - Round-robin over `req_valid`. The search starts at `last_grant+1` and wraps modulo NUM_REQ.
  - `req_ready[i] = grant[i] && adv`.
  - The grant is computed combinationally from `req_valid` and `last_grant`. `req_ready` never depends on `req_valid[j]` for j lower in the search order than the granted requester.
- Pointer: `last_grant` updates only on an accepted input transfer. It holds while stalled or idle.
- Operand path: the granted requester's operands are muxed into the shared multiplier. The product is captured with its id in the output register when `adv` is high.
- Output register:
  - If `adv` is high and there is no grant, `out_valid` drops to 0 on the next edge.
  - While `out_valid && !out_ready`, the output holds `out_real`, `out_cplx` and `out_id` stable.
- Arithmetic: products are taken unmodified from the multiplier (its own rounding and saturation). This block performs no width change.
- Boundary behaviour:
  - A single active requester is granted every cycle. It sustains one result per cycle when `out_ready=1`.
  - If a requester drops `req_valid` while not granted, nothing is lost.
  - If the granted requester deasserts `req_valid` while stalled, the grant is recomputed on the next cycle. The pointer is unchanged.
  - Reset mid-operation discards every in-flight result without an output transfer.

## Timing
- Reset values:
  - `out_valid=0`, `out_real=0`, `out_cplx=0`, `out_id=0`, `busy=0`, `req_ready=0`.
  - `last_grant=NUM_REQ-1`, so requester 0 wins first.
- Latency: 1 cycle from input transfer to `out_valid` (2 cycles with `CMUL_IN_REG_EN`).
- Throughput: 1 operation per cycle aggregate. Under full contention each requester gets 1 of every NUM_REQ cycles.
- The output is fully registered. The combinational path from `out_ready` to `req_ready` is allowed.

## Configuration
- Macro: `CMUL_IN_REG_EN`.
- Defined:
  - A stage-1 register captures the muxed operands, id and valid bit before the multiplier.
  - Latency becomes 2 cycles and stage 1 advances on `adv`.
  - `busy` is the OR of both valid bits.
- Undefined: the mux feeds the multiplier directly, with 1-cycle latency.

## Structure
- Shared package `cmul_pkg` holds:
  - typedef `cplx_t` (struct of `re` and `im`, each SIZE bits);
  - constants `CMUL_SIZE=16`, `CMUL_FRAC=8`, `CMUL_NUM_REQ=4`.
- Sub-module `rr_arbiter`, parameterised on N:
  - inputs: `req`, `adv`;
  - outputs: one-hot `grant`, encoded `grant_id`;
  - owns the `last_grant` register.
- The multiplier is instantiated once inside `cmul_arbiter`.

## Test plan
All cases use SIZE=16 and FRAC_BITS=8, so 1.0 = 0x0100.
- **Single product:** requester 2 presents (1+2i)·(3+4i), i.e. 0x0100, 0x0200, 0x0300, 0x0400, with `out_ready=1` → next cycle `out_valid=1`, `out_real=0xFB00`, `out_cplx=0x0A00`, `out_id=2`.
- **Fairness:** all 4 requesters hold valid for 8 cycles with `out_ready=1` → grant order 0,1,2,3,0,1,2,3 and exactly 2 results per id.
- **Back-pressure:**
  - stimulus: `out_ready=0` for 5 cycles with requests pending;
  - required: `req_ready` is all zero, the output is stable with its values unchanged, and `last_grant` is frozen;
  - after release: results resume in the correct round-robin order, with no loss or duplication.
- **Sparse requests:** only requesters 1 and 3 valid → grants alternate 1,3,1,3 and idle slots are skipped.
- **Mid-flight reset:** assert `rst_n=0` with `out_valid=1` → all outputs are immediately 0; after release, the first grant goes to requester 0.
- **`CMUL_IN_REG_EN` build:** repeat the single-product and back-pressure cases → result appears 2 cycles after the transfer, and values and ordering are identical to the default build.
